// File: rtl/w_mem_fetch_unit_pkg.sv
// ============================================================================
// Module  : w_mem_fetch_unit_pkg
// Brief   : Shared state encoding and default buffer depth for the fetch unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package w_mem_fetch_unit_pkg;

  localparam int FETCH_FIFO_DEPTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_DRAIN = ST_DRAIN
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/w_mem_fetch_unit_if.sv
// ============================================================================
// Module  : w_mem_fetch_unit_if
// Brief   : Weight-memory read port plus the valid/ready weight-row stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface w_mem_fetch_unit_if #(
  parameter int BLOCKS_PER_ROW = 4,
  parameter int NUM_BIT        = 8,
  parameter int ADDR_W         = 13
);

  logic                                          mem_rd_enable;
  logic [ADDR_W-1:0]                             mem_rd_addr;
  logic signed [BLOCKS_PER_ROW-1:0][NUM_BIT-1:0] mem_rd_data;
  logic                                          w_valid;
  logic                                          w_ready;
  logic signed [BLOCKS_PER_ROW-1:0][NUM_BIT-1:0] w_data;
  logic                                          w_last;

  modport master (
    output mem_rd_enable, mem_rd_addr, w_valid, w_data, w_last,
    input  mem_rd_data, w_ready
  );

  modport slave (
    input  mem_rd_enable, mem_rd_addr, w_valid, w_data, w_last,
    output mem_rd_data, w_ready
  );

endinterface

`default_nettype wire

// File: rtl/w_fetch_fifo.sv
// ============================================================================
// Module  : w_fetch_fifo
// Brief   : Show-ahead row buffer carrying a last-row flag, with occupancy out
// Revision: 1.0
// ============================================================================
`default_nettype none

module w_fetch_fifo
  import w_mem_fetch_unit_pkg::*;
#(
  parameter  int DEPTH  = FETCH_FIFO_DEPTH,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W:0]    w_head;
  logic               w_pop;

  assign valid     = (r_count != '0);
  assign w_pop     = pop && valid;
  assign w_head    = r_mem[r_rd_ptr];
  assign head_data = valid ? w_head[DATA_W-1:0] : '0;
  assign head_last = valid & w_head[DATA_W];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= {push_last, push_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/w_mem_fetch_unit.sv
// ============================================================================
// Module  : w_mem_fetch_unit
// Brief   : Strided weight-row fetcher feeding a show-ahead buffer to the MACs
// Revision: 1.0
// ============================================================================
`default_nettype none

module w_mem_fetch_unit
  import w_mem_fetch_unit_pkg::*;
#(
  parameter int BLOCKS_PER_ROW = 4,
  parameter int NUM_BIT        = 8,
  parameter int ADDR_W         = 13,
  parameter int FIFO_DEPTH     = FETCH_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [15:0]        num_rows,
  input  logic [ADDR_W-1:0]  stride,
  output logic               busy,
  output logic               done,
  w_mem_fetch_unit_if.master bus
);

  localparam int             ROW_W   = BLOCKS_PER_ROW * NUM_BIT;
  localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [15:0]       r_rows_left;
  logic              r_pending;
  logic              r_pend_last;
  logic              r_done;

  logic              w_issue;
  logic              w_final_issue;
  logic              w_pop;
  logic              w_drain_ok;
  logic              w_fifo_valid;
  logic              w_fifo_last;
  logic [ROW_W-1:0]  w_fifo_data;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occupancy;

  // Occupancy counts the in-flight read but gives no credit for a same-cycle pop.
  assign w_occupancy   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_pending};
  assign w_issue       = (r_state == S_FETCH) && (r_rows_left != 16'd0) && (w_occupancy < C_DEPTH);
  assign w_final_issue = w_issue && (r_rows_left == 16'd1);
  assign w_pop         = w_fifo_valid && bus.w_ready;
  // Buffer is empty after this edge: nothing in flight and at most the head leaving.
  assign w_drain_ok    = !r_pending && ((w_count == '0) || ((w_count == CNT_W'(1)) && w_pop));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_stride    <= '0;
      r_rows_left <= '0;
      r_pending   <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_pending   <= w_issue;
      r_pend_last <= w_final_issue;
      if (w_issue) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= r_next_addr + r_stride;
        r_rows_left <= r_rows_left - 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_next_addr <= base_addr;
            r_stride    <= stride;
            r_rows_left <= num_rows;
            r_state     <= (num_rows != 16'd0) ? S_FETCH : S_DRAIN;
          end
        end
        S_FETCH: begin
          if (w_final_issue) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drain_ok) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  w_fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ROW_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_pending),
    .push_data (bus.mem_rd_data),
    .push_last (r_pend_last),
    .pop       (w_pop),
    .valid     (w_fifo_valid),
    .head_data (w_fifo_data),
    .head_last (w_fifo_last),
    .count     (w_count)
  );

  assign busy              = (r_state != S_IDLE);
  assign done              = r_done;
  assign bus.mem_rd_enable = w_issue;
  assign bus.mem_rd_addr   = w_issue ? r_next_addr : r_last_addr;
  assign bus.w_valid       = w_fifo_valid;
  assign bus.w_data        = w_fifo_data;
  assign bus.w_last        = w_fifo_last;

endmodule

`default_nettype wire

// File: tb/tb_w_mem_fetch_unit.sv
// ============================================================================
// Module  : tb_w_mem_fetch_unit
// Brief   : Randomised jobs against a row-address/scoreboard model of the fetcher
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_w_mem_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic [12:0] base_addr = '0;
  logic [15:0] num_rows  = '0;
  logic [12:0] stride    = '0;
  logic        busy;
  logic        done;

  w_mem_fetch_unit_if #(.BLOCKS_PER_ROW(4), .NUM_BIT(8), .ADDR_W(13)) bus ();

  w_mem_fetch_unit #(
    .BLOCKS_PER_ROW (4),
    .NUM_BIT        (8),
    .ADDR_W         (13),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .stride    (stride),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency
  logic [31:0] mem_model [8192];
  always @(posedge clk) begin
    if (bus.mem_rd_enable) bus.mem_rd_data <= mem_model[bus.mem_rd_addr];
  end

  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [31:0] pop_data_q[$];
  bit          pop_last_q[$];
  int          pop_cyc_q[$];
  int          done_cyc_q[$];
  int          cyc = 0, t0 = 0, n_iss = 0, n_pop = 0, max_occ = 0, hold_err = 0;
  logic [12:0] last_addr = '0;
  int          n_vec = 0, n_err = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (n_iss - n_pop > max_occ) max_occ = n_iss - n_pop;
    if (bus.mem_rd_enable) begin
      rd_addr_q.push_back(int'(bus.mem_rd_addr));
      rd_cyc_q.push_back(cyc - t0);
      last_addr = bus.mem_rd_addr;
      n_iss++;
    end else if (bus.mem_rd_addr !== last_addr) begin
      hold_err++;
    end
    if (bus.w_valid && bus.w_ready) begin
      pop_data_q.push_back(bus.w_data);
      pop_last_q.push_back(bus.w_last);
      pop_cyc_q.push_back(cyc - t0);
      n_pop++;
    end
    if (done) done_cyc_q.push_back(cyc - t0);
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k > 20);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // Row i of a job lives at (base + i*stride) mod 2^13 and is last when i == n-1.
  task automatic run_job(input int base, input int n, input int strd, input int mode,
                         input bit poke, input int abort_after, output bit aborted);
    int          k;
    int          budget;
    logic [12:0] ea;
    rd_addr_q.delete(); rd_cyc_q.delete(); pop_data_q.delete();
    pop_last_q.delete(); pop_cyc_q.delete(); done_cyc_q.delete();
    hold_err = 0;
    aborted  = 1'b0;
    budget   = 40 + n * 12;
    tick();
    t0          = cyc;
    start       = 1'b1;
    base_addr   = 13'(base);
    num_rows    = 16'(n);
    stride      = 13'(strd);
    bus.w_ready = ready_for(mode, 0);
    k = 0;
    while (done_cyc_q.size() == 0 && k < budget) begin
      tick();
      k++;
      start = 1'b0;
      if (poke && k == 4) begin
        chk_eq("busy_at_poke", busy, 1);
        start     = 1'b1;
        base_addr = 13'h555;
        num_rows  = 16'd2;
        stride    = 13'd1;
      end
      bus.w_ready = ready_for(mode, k);
      if (abort_after > 0 && pop_cyc_q.size() >= abort_after) begin
        reset     = 1'b0;
        last_addr = '0;
        n_iss     = 0;
        n_pop     = 0;
        #1;
        chk_eq("abort_outputs",
               {busy, done, bus.mem_rd_enable, bus.mem_rd_addr, bus.w_valid, bus.w_last}, 64'd0);
        repeat (3) tick();
        chk_eq("abort_no_done", done_cyc_q.size(), 0);
        reset = 1'b1;
        tick();
        chk_eq("abort_no_done_after", done_cyc_q.size(), 0);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk_eq("job_completes", done_cyc_q.size() > 0, 1);
      tick();
      chk_eq("done_single_pulse", done_cyc_q.size(), 1);
      chk_eq("idle_after_done", busy, 0);
      chk_eq("read_count", rd_addr_q.size(), n);
      chk_eq("row_count", pop_data_q.size(), n);
      for (int i = 0; i < n; i++) begin
        ea = 13'(base + i * strd);
        if (i < rd_addr_q.size()) chk_eq("read_addr", rd_addr_q[i], ea);
        if (i < pop_data_q.size()) begin
          chk_eq("row_data", pop_data_q[i], mem_model[ea]);
          chk_eq("row_last", pop_last_q[i], i == n - 1);
        end
      end
      chk_eq("addr_hold", hold_err, 0);
    end
  endtask

  initial begin
    bit ab;
    int lasts;
    int early;
    for (int i = 0; i < 8192; i++) mem_model[i] = $urandom;
    bus.w_ready = 1'b0;
    tick();
    tick();
    chk_eq("reset_state",
           {busy, done, bus.mem_rd_enable, bus.mem_rd_addr, bus.w_valid, bus.w_last}, 64'd0);
    reset = 1'b1;
    tick();

    // Reference job with an ignored start while busy
    run_job(32'h010, 8, 4, 0, 1'b1, 0, ab);
    chk_eq("A_first_read_cyc", q_at(rd_cyc_q, 0), 1);
    chk_eq("A_last_read_cyc", q_at(rd_cyc_q, 7), 8);
    chk_eq("A_first_valid_cyc", q_at(pop_cyc_q, 0), 3);
    chk_eq("A_last_valid_cyc", q_at(pop_cyc_q, 7), 10);
    chk_eq("A_done_cyc", q_at(done_cyc_q, 0), 11);

    // Back-pressure: consumer stalled for cycles 0..20
    run_job(32'h010, 8, 4, 1, 1'b0, 0, ab);
    early = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] <= 20) early++;
    chk_eq("B_reads_while_stalled", early, DEPTH);

    // Address wrap-around
    run_job(32'h1FFC, 3, 4, 0, 1'b0, 0, ab);
    chk_eq("C_wrap_addr0", q_at(rd_addr_q, 0), 32'h1FFC);
    chk_eq("C_wrap_addr1", q_at(rd_addr_q, 1), 0);
    chk_eq("C_wrap_addr2", q_at(rd_addr_q, 2), 4);

    // Empty job
    run_job(32'h123, 0, 7, 0, 1'b0, 0, ab);
    chk_eq("D_done_cyc", q_at(done_cyc_q, 0), 2);

    // Mid-job reset, then a fresh job
    run_job(32'h200, 8, 3, 0, 1'b0, 3, ab);
    chk_eq("E_abort_taken", ab, 1);
    run_job(int'($urandom_range(8191, 0)), 8, int'($urandom_range(8191, 0)), 0, 1'b0, 0, ab);

    // Long job with random back-pressure
    run_job(int'($urandom_range(8191, 0)), 64, int'($urandom_range(8191, 0)), 2, 1'b0, 0, ab);
    lasts = 0;
    foreach (pop_last_q[i]) lasts += int'(pop_last_q[i]);
    chk_eq("G_last_once", lasts, 1);

    for (int j = 0; j < 5; j++) begin
      run_job(int'($urandom_range(8191, 0)), int'($urandom_range(16, 1)),
              int'($urandom_range(8191, 0)), 2, 1'b0, 0, ab);
    end

    chk_eq("occupancy_bound", max_occ <= DEPTH, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/w_mem_fetch_unit.md
W_MEM_FETCH_UNIT -- requirements
Module: w_mem_fetch_unit

Interface
REQ-001 Parameter BLOCKS_PER_ROW, default 4: number of weight words per memory row (lanes).
REQ-002 Parameter NUM_BIT, default 8: bits per weight word.
REQ-003 Parameter ADDR_W, default 13: width of the weight-memory read address (total word address).
REQ-004 Parameter FIFO_DEPTH, default 4, power of two, minimum 2: output buffer entries.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low.
REQ-007 start  in  1  single-cycle request to begin a fetch job; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_W  first read address of the job.
REQ-009 num_rows  in  16  number of rows to fetch, unsigned.
REQ-010 stride  in  ADDR_W  address increment between rows.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 done  out  1  single-cycle pulse when the job completes.
REQ-013 mem_rd_enable  out  1  read strobe to the weight memory.
REQ-014 mem_rd_addr  out  ADDR_W  read address to the weight memory.
REQ-015 mem_rd_data  in  BLOCKS_PER_ROW x NUM_BIT signed  row returned by the weight memory.
REQ-016 w_valid  out  1  w_data holds a valid row.
REQ-017 w_ready  in  1  consumer (MAC array) accepts the row.
REQ-018 w_data  out  BLOCKS_PER_ROW x NUM_BIT signed  weight row to the consumer.
REQ-019 w_last  out  1  qualifies the final row of a job; meaningful only with w_valid.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH and DRAIN.
REQ-021 In IDLE, start=1 SHALL latch base_addr, num_rows and stride; the FSM then enters FETCH if num_rows>0, otherwise DRAIN.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 In FETCH, a read SHALL be issued (mem_rd_enable=1) only when fifo_count + pending + 1 <= FIFO_DEPTH; fifo_count excludes a pop in the same cycle.
REQ-024 pending SHALL be a 1-bit flag set in the cycle after an issue; when set, mem_rd_data SHALL be written into the FIFO at that cycle's clock edge.
REQ-025 Memory read latency SHALL be treated as exactly one cycle.
REQ-026 The first read address SHALL be base_addr; each further read SHALL add stride, modulo 2^ADDR_W (wrap-around without error).
REQ-027 mem_rd_addr SHALL hold the last issued address whenever mem_rd_enable=0, so that the memory's bank-switch tracking sees a stable address.
REQ-028 After num_rows reads have been issued, FETCH SHALL go to DRAIN.
REQ-029 DRAIN SHALL wait until pending=0 and the FIFO is empty, pulse done for one cycle, and return to IDLE in the same transition.
REQ-030 The FIFO SHALL be show-ahead: w_valid = not empty, w_data = head entry; a pop occurs when w_valid and w_ready are both 1.
REQ-031 A simultaneous push and pop SHALL leave the occupancy unchanged; the FIFO SHALL never overflow, guaranteed by REQ-023.
REQ-032 w_last SHALL be stored with the entry that holds row num_rows-1.
REQ-033 With w_ready held at 1, throughput SHALL be one row per cycle.
REQ-034 Latency SHALL be: start sampled at the end of cycle 0, mem_rd_enable high in cycle 1, first w_valid in cycle 3.
REQ-035 With num_rows=0, no read SHALL be issued and done SHALL pulse in cycle 2.

Reset
REQ-036 While reset=0, all of the following SHALL be 0: FSM (IDLE), busy, done, mem_rd_enable, mem_rd_addr, pending, FIFO pointers and count, w_valid, w_last.
REQ-037 A reset asserted in mid-job SHALL abort the job and flush the FIFO; done SHALL NOT pulse.

Structure
REQ-038 The FSM state enum and the default FETCH_FIFO_DEPTH constant SHALL reside in the shared parameters package.
REQ-039 The buffer SHALL be a sub-module w_fetch_fifo: synchronous, show-ahead, data plus last-flag, with count output.

Verification
REQ-040 base=0x010, stride=4, num_rows=8, w_ready=1 -> reads at 0x010..0x02C in cycles 1-8, w_valid cycles 3-10, w_last in cycle 10, done in cycle 11.
REQ-041 Same job with w_ready=0 for cycles 0-20 -> exactly 4 reads issued, then mem_rd_enable stays 0; after w_ready rises, all 8 rows arrive in order with no loss or duplication.
REQ-042 base=0x1FFC, stride=4, num_rows=3 -> addresses 0x1FFC, 0x0000, 0x0004.
REQ-043 num_rows=0 -> no mem_rd_enable, done in cycle 2; a start while busy=1 -> ignored, job parameters unchanged.
REQ-044 reset pulled low after 3 rows of an 8-row job -> all outputs 0 immediately, no done; a new job afterwards runs correctly.
REQ-045 Random w_ready at 50% over 64 rows -> the scoreboard matches the memory model, w_last appears exactly once, and the occupancy never exceeds FIFO_DEPTH.
